// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shifter with self-generated serial clock and latch strobe.
// Latency: first bit on sdata one cycle after accept; word done after 2*CLK_DIV*WIDTH+CLK_DIV cycles.
// Backpressure: in_ready high only in IDLE; in_valid is ignored while a word is in flight.
//
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   in_data/in_valid/in_ready   parallel word handshake
//   sclk, sdata, sload    serial link to the downstream shift register (all registered)
//   busy                  high while a word is being shifted or latched
module piso_shifter #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             sload,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int DW = $clog2(CLK_DIV) + 1;

  // Divider runs 0 .. 2*CLK_DIV-1 across one bit in SHIFT, 0 .. CLK_DIV-1 in LATCH.
  localparam logic [DW-1:0] DIV_BIT_LAST   = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HIGH_START = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LATCH_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST       = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shreg_shifted;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [DW-1:0]    div_cnt, div_cnt_nxt, div_inc;
  logic             sclk_nxt, sload_nxt, in_ready_nxt, busy_nxt;

  // Zeros shift in behind the word, so after the final shift (done on entry
  // to LATCH) the register is empty and sdata idles low without extra muxing.
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
  assign sdata         = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign div_inc       = div_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      sclk     <= 1'b0;
      sload    <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      div_cnt  <= div_cnt_nxt;
      sclk     <= sclk_nxt;
      sload    <= sload_nxt;
      in_ready <= in_ready_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    div_cnt_nxt  = div_cnt;
    sclk_nxt     = 1'b0;
    sload_nxt    = 1'b0;
    in_ready_nxt = 1'b0;
    busy_nxt     = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready_nxt = 1'b1;
        busy_nxt     = 1'b0;
        if (in_valid && in_ready) begin
          shreg_nxt    = in_data;
          bit_cnt_nxt  = BIT_LAST;
          div_cnt_nxt  = '0;
          state_nxt    = SHIFT;
          in_ready_nxt = 1'b0;
          busy_nxt     = 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_BIT_LAST) begin
          // End of high phase: sclk falls and the next bit appears on the same edge.
          div_cnt_nxt = '0;
          shreg_nxt   = shreg_shifted;
          if (bit_cnt != '0) begin
            bit_cnt_nxt = bit_cnt - 1'b1;
          end else begin
            state_nxt = LATCH;
            sload_nxt = 1'b1;
          end
        end else begin
          div_cnt_nxt = div_inc;
          sclk_nxt    = (div_inc >= DIV_HIGH_START);
        end
      end
      LATCH: begin
        if (div_cnt == DIV_LATCH_LAST) begin
          div_cnt_nxt  = '0;
          state_nxt    = IDLE;
          in_ready_nxt = 1'b1;
          busy_nxt     = 1'b0;
        end else begin
          div_cnt_nxt = div_inc;
          sload_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        in_ready_nxt = 1'b1;
        busy_nxt     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_shifter.sv
// Bench for piso_shifter: three instances (defaults, LSB-first, WIDTH=16/CLK_DIV=1).
// Expected serial bits are queued at accept and popped on each observed sclk rise.
module tb_piso_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  vld;
  logic [15:0] dat [3];
  logic [2:0]  rdy, sck, sdt, sld, bsy;

  int vectors = 0;
  int errors  = 0;

  bit exp_q [3][$];
  int rises [3];
  int loads [3];
  logic [2:0] prev_sck, prev_sld, prev_sdt;

  always #5 clk = ~clk;

  piso_shifter #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset_n(rst_n), .in_data(dat[0][7:0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .sclk(sck[0]), .sdata(sdt[0]), .sload(sld[0]), .busy(bsy[0]));

  piso_shifter #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset_n(rst_n), .in_data(dat[1][7:0]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .sclk(sck[1]), .sdata(sdt[1]), .sload(sld[1]), .busy(bsy[1]));

  piso_shifter #(.WIDTH(16), .CLK_DIV(1), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .reset_n(rst_n), .in_data(dat[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .sclk(sck[2]), .sdata(sdt[2]), .sload(sld[2]), .busy(bsy[2]));

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (sck[k] && !prev_sck[k]) begin
        rises[k]++;
        vectors++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL spurious_sclk dut%0d got=rise exp=no_rise", k);
        end else begin
          bit e;
          e = exp_q[k].pop_front();
          if (sdt[k] !== e) begin
            errors++;
            $display("FAIL serial_bit dut%0d got=%0b exp=%0b", k, sdt[k], e);
          end
        end
      end
      if (sld[k] && !prev_sld[k]) loads[k]++;
      vectors++;
      if (sld[k] && (sck[k] || sdt[k])) begin
        errors++;
        $display("FAIL latch_idle dut%0d got=sclk%0b/sdata%0b exp=0/0", k, sck[k], sdt[k]);
      end
      vectors++;
      if (bsy[k] === rdy[k]) begin
        errors++;
        $display("FAIL busy_vs_ready dut%0d got=busy%0b exp=~ready%0b", k, bsy[k], rdy[k]);
      end
      if (sdt[k] != prev_sdt[k] && sck[k]) begin
        errors++;
        $display("FAIL sdata_while_sclk_high dut%0d got=change exp=stable", k);
      end
    end
    prev_sck <= sck;
    prev_sld <= sld;
    prev_sdt <= sdt;
  end

  // Must be called on a falling edge. Presents the word, accepts on the next
  // rising edge (cycle 0), then checks per-cycle sclk/sload/in_ready through the
  // first cycle in_ready returns. hold keeps in_valid asserted; toggle scrambles
  // in_data while busy; next_data is on in_data in the final cycle.
  task automatic run_word(input int k, input logic [15:0] data, input int w, input int cd,
                          input bit msb, input bit hold, input bit toggle,
                          input logic [15:0] next_data);
    int t;
    int r0, l0;
    logic e_sck, e_sld, e_rdy;
    t = 2 * cd * w;
    dat[k] = data;
    vld[k] = 1'b1;
    vectors++;
    if (rdy[k] !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready dut%0d got=%0b exp=1", k, rdy[k]);
    end
    @(posedge clk);
    for (int i = 0; i < w; i++) exp_q[k].push_back(msb ? data[w-1-i] : data[i]);
    #1;
    r0 = rises[k];
    l0 = loads[k];
    for (int c = 1; c <= t + cd + 1; c++) begin
      @(negedge clk);
      vld[k] = hold;
      if (c == t + cd + 1) dat[k] = next_data;
      else if (toggle) dat[k] = 16'($urandom);
      e_sck = (c <= t) && (((c - 1) % (2 * cd)) >= cd);
      e_sld = (c > t) && (c <= t + cd);
      e_rdy = (c > t + cd);
      vectors += 3;
      if (sck[k] !== e_sck) begin
        errors++;
        $display("FAIL sclk_timing dut%0d c=%0d got=%0b exp=%0b", k, c, sck[k], e_sck);
      end
      if (sld[k] !== e_sld) begin
        errors++;
        $display("FAIL sload_timing dut%0d c=%0d got=%0b exp=%0b", k, c, sld[k], e_sld);
      end
      if (rdy[k] !== e_rdy) begin
        errors++;
        $display("FAIL ready_timing dut%0d c=%0d got=%0b exp=%0b", k, c, rdy[k], e_rdy);
      end
    end
    #1;
    vectors += 3;
    if (rises[k] - r0 != w) begin
      errors++;
      $display("FAIL sclk_rise_count dut%0d got=%0d exp=%0d", k, rises[k] - r0, w);
    end
    if (loads[k] - l0 != 1) begin
      errors++;
      $display("FAIL sload_pulse_count dut%0d got=%0d exp=1", k, loads[k] - l0);
    end
    if (exp_q[k].size() != 0) begin
      errors++;
      $display("FAIL bits_left dut%0d got=%0d exp=0", k, exp_q[k].size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld   = '0;
    for (int k = 0; k < 3; k++) dat[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors += 5;
      if (rdy[k] !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d got=%0b exp=1", k, rdy[k]); end
      if (sck[k] !== 1'b0) begin errors++; $display("FAIL reset_sclk dut%0d got=%0b exp=0", k, sck[k]); end
      if (sdt[k] !== 1'b0) begin errors++; $display("FAIL reset_sdata dut%0d got=%0b exp=0", k, sdt[k]); end
      if (sld[k] !== 1'b0) begin errors++; $display("FAIL reset_sload dut%0d got=%0b exp=0", k, sld[k]); end
      if (bsy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got=%0b exp=0", k, bsy[k]); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_msb_first();
    @(negedge clk);
    run_word(0, 16'h001E, 8, 2, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_lsb_first();
    @(negedge clk);
    run_word(1, 16'h001E, 8, 2, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    run_word(0, 16'h00FF, 8, 2, 1'b1, 1'b1, 1'b0, 16'h0000);
    run_word(0, 16'h0000, 8, 2, 1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_ignored_input();
    @(negedge clk);
    run_word(0, 16'h003C, 8, 2, 1'b1, 1'b1, 1'b1, 16'h00A5);
    run_word(0, 16'h00A5, 8, 2, 1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_reset_mid_word();
    int l0, r0;
    @(negedge clk);
    dat[0] = 16'h00AA;
    vld[0] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) exp_q[0].push_back(dat[0][7-i]);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      vld[0] = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) exp_q[k].delete();
    vectors += 5;
    if (sck[0] !== 1'b0) begin errors++; $display("FAIL midrst_sclk got=%0b exp=0", sck[0]); end
    if (sdt[0] !== 1'b0) begin errors++; $display("FAIL midrst_sdata got=%0b exp=0", sdt[0]); end
    if (sld[0] !== 1'b0) begin errors++; $display("FAIL midrst_sload got=%0b exp=0", sld[0]); end
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%0b exp=1", rdy[0]); end
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b exp=0", bsy[0]); end
    l0 = loads[0];
    r0 = rises[0];
    repeat (40) @(negedge clk);
    #1;
    vectors += 2;
    if (loads[0] != l0) begin errors++; $display("FAIL midrst_no_sload got=%0d exp=%0d", loads[0], l0); end
    if (rises[0] != r0) begin errors++; $display("FAIL midrst_no_sclk got=%0d exp=%0d", rises[0], r0); end
    @(negedge clk);
    run_word(0, 16'h0055, 8, 2, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_corner_params();
    @(negedge clk);
    run_word(2, 16'h8001, 16, 1, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rises[k] = 0;
      loads[k] = 0;
    end
    prev_sck = '0;
    prev_sld = '0;
    prev_sdt = '0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_ignored_input();
    test_reset_mid_word();
    test_corner_params();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
